// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: sync pattern, payload MSB-first, one idle gap bit.
// Optional parity bit after the payload when SEQ_FRAME_TX_PARITY_EN is defined.
module seq_frame_tx #(
  parameter int              DATA_W   = 8,
  parameter int              SYNC_W   = 4,
  parameter logic [SYNC_W-1:0] SYNC_PAT = 4'b1011
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              x_out,
  output logic              tx_active,
  output logic              done
);

  localparam int MAX_W = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
  localparam int CNT_W = (MAX_W > 1) ? $clog2(MAX_W) : 1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SYNC = 3'd1,
    ST_DATA = 3'd2,
`ifdef SEQ_FRAME_TX_PARITY_EN
    ST_PAR  = 3'd3,
`endif
    ST_GAP  = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
`ifdef SEQ_FRAME_TX_PARITY_EN
  logic                par_q, par_d;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
`ifdef SEQ_FRAME_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
`ifdef SEQ_FRAME_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
`ifdef SEQ_FRAME_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          shreg_d = in_data;
          cnt_d   = CNT_W'(SYNC_W - 1);
          state_d = ST_SYNC;
`ifdef SEQ_FRAME_TX_PARITY_EN
          par_d   = ^in_data;
`endif
        end
      end
      ST_SYNC: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          cnt_d   = CNT_W'(DATA_W - 1);
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        shreg_d = shreg_q << 1;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
`ifdef SEQ_FRAME_TX_PARITY_EN
          state_d = ST_PAR;
`else
          state_d = ST_GAP;
`endif
        end
      end
`ifdef SEQ_FRAME_TX_PARITY_EN
      ST_PAR:  state_d = ST_GAP;
`endif
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Moore outputs decoded from registered state only.
  always_comb begin
    x_out     = 1'b0;
    in_ready  = 1'b0;
    tx_active = 1'b0;
    done      = 1'b0;
    case (state_q)
      ST_IDLE: in_ready = 1'b1;
      ST_SYNC: begin
        x_out     = |(SYNC_PAT & (SYNC_W'(1) << cnt_q));
        tx_active = 1'b1;
      end
      ST_DATA: begin
        x_out     = shreg_q[DATA_W-1];
        tx_active = 1'b1;
      end
`ifdef SEQ_FRAME_TX_PARITY_EN
      ST_PAR: begin
        x_out     = par_q;
        tx_active = 1'b1;
      end
`endif
      ST_GAP:  done = 1'b1;
      default: x_out = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_seq_frame_tx.sv
// Scoreboard bench for seq_frame_tx: the driver predicts each frame bit with its
// cycle stamp; a negedge monitor pops and compares. Includes a 1011 loopback detector.
module tb_seq_frame_tx;

  localparam int DW = 8;
  localparam int SW = 4;
  localparam logic [SW-1:0] PAT = 4'b1011;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready, x_out, tx_active, done;

  seq_frame_tx #(.DATA_W(DW), .SYNC_W(SW), .SYNC_PAT(PAT)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .x_out     (x_out),
    .tx_active (tx_active),
    .done      (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic x;
    logic d;
    int   cyc;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   free_edge = 0;
  int   exp_hits = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Non-overlapping 1011 count over a bit stream.
  function automatic int count_1011(input logic b[$]);
    int n = 0;
    int i = 0;
    while (i + 3 < b.size()) begin
      if (b[i] && !b[i+1] && b[i+2] && b[i+3]) begin
        n++;
        i += 4;
      end else begin
        i++;
      end
    end
    return n;
  endfunction

  // Frame accepted at edge e: bit k of the frame is on the line during cycle e+k.
  task automatic push_frame(input logic [DW-1:0] d, input int e);
    logic          b[$];
    logic [SW-1:0] pat_v = PAT;
    for (int i = SW - 1; i >= 0; i--) b.push_back(pat_v[i]);
    for (int i = DW - 1; i >= 0; i--) b.push_back(d[i]);
`ifdef SEQ_FRAME_TX_PARITY_EN
    b.push_back(^d);
`endif
    for (int i = 0; i < b.size(); i++) q.push_back('{x: b[i], d: 1'b0, cyc: e + i});
    q.push_back('{x: 1'b0, d: 1'b1, cyc: e + b.size()});
    exp_hits += count_1011(b);
    free_edge = e + b.size() + 2;
  endtask

  task automatic step(input logic v, input logic [DW-1:0] d, output logic acc);
    @(negedge clk);
    in_valid = v;
    in_data  = d;
    acc = v && (reset_n === 1'b1) && (cyc + 1 >= free_edge);
    if (acc) push_frame(d, cyc + 1);
  endtask

  task automatic send(input logic [DW-1:0] d);
    logic acc;
    int   n = 0;
    do begin
      step(1'b1, d, acc);
      n++;
    end while (!acc && n < 100);
    step(1'b0, DW'($urandom), acc);
  endtask

  task automatic wait_idle();
    logic acc;
    int   n = 0;
    while (cyc < free_edge && n < 200) begin
      step(1'b0, DW'($urandom), acc);
      n++;
    end
    step(1'b0, DW'($urandom), acc);
  endtask

  // Monitor: frame bits are compared against the scoreboard, idle cycles against constants.
  always @(negedge clk) begin
    exp_t e;
    if (tx_active === 1'b1 || done === 1'b1) begin
      if (q.size() == 0) begin
        check("unexpected_frame_bit", {30'd0, tx_active, done}, 32'd0);
      end else begin
        e = q.pop_front();
        check("bit_cycle", cyc, e.cyc);
        check("x_out", {31'd0, x_out}, {31'd0, e.x});
        check("done", {31'd0, done}, {31'd0, e.d});
        check("tx_active", {31'd0, tx_active}, {31'd0, !e.d});
        check("busy_in_ready", {31'd0, in_ready}, 32'd0);
      end
    end else begin
      check("idle_x_out", {31'd0, x_out}, 32'd0);
      check("idle_in_ready", {31'd0, in_ready}, 32'd1);
      if (q.size() > 0 && q[0].cyc <= cyc) begin
        check("missing_frame_bit", {31'd0, tx_active | done}, 32'd1);
        void'(q.pop_front());
      end
    end
  end

  // Receiver-side 1011 Moore detector, non-overlapping.
  typedef enum logic [2:0] {D0, D1, D10, D101, D1011} det_e;
  det_e det_q;
  int   det_hits = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) det_q <= D0;
    else begin
      case (det_q)
        D0:      det_q <= x_out ? D1 : D0;
        D1:      det_q <= x_out ? D1 : D10;
        D10:     det_q <= x_out ? D101 : D0;
        D101:    det_q <= x_out ? D1011 : D10;
        default: det_q <= x_out ? D1 : D0;
      endcase
    end
  end

  always @(negedge clk) if (det_q == D1011) det_hits <= det_hits + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    int   e0, hits_base, exp_base;

    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Quiet line after reset.
    repeat (10) step(1'b0, DW'($urandom), acc);

    // Directed frames, including parity-sensitive words.
    send(8'hA5);
    wait_idle();
    send(8'h07);
    wait_idle();

    // Back-to-back with in_valid held high.
    acc = 1'b0;
    for (int n = 0; n < 100 && !acc; n++) step(1'b1, 8'h01, acc);
    acc = 1'b0;
    for (int n = 0; n < 100 && !acc; n++) step(1'b1, 8'h02, acc);
    step(1'b0, 8'h00, acc);
    wait_idle();

    // Asynchronous reset during the third data bit.
    acc = 1'b0;
    for (int n = 0; n < 100 && !acc; n++) step(1'b1, 8'hFF, acc);
    e0 = free_edge - (SW + DW + 2);
`ifdef SEQ_FRAME_TX_PARITY_EN
    e0 = e0 - 1;
`endif
    for (int n = 0; n < 100 && cyc < e0 + SW + 2; n++) step(1'b0, 8'h00, acc);
    #2;
    reset_n = 1'b0;
    q.delete();
    free_edge = 0;
    #1;
    check("rst_x_out", {31'd0, x_out}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_tx_active", {31'd0, tx_active}, 32'd0);
    repeat (3) step(1'b0, 8'h00, acc);
    reset_n = 1'b1;
    send(8'h3C);
    wait_idle();

    // Loopback detector hit count.
    repeat (3) step(1'b0, 8'h00, acc);
    hits_base = det_hits;
    exp_base  = exp_hits;
    send(8'h00);
    wait_idle();
    send(8'h0B);
    wait_idle();
    repeat (3) step(1'b0, 8'h00, acc);
    check("detector_hits", det_hits - hits_base, exp_hits - exp_base);

    // Random traffic.
    for (int n = 0; n < 300; n++) step(($urandom_range(0, 3) == 0), DW'($urandom), acc);
    step(1'b0, 8'h00, acc);
    wait_idle();
    repeat (3) step(1'b0, 8'h00, acc);
    check("queue_drained", q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
